ud_counter_ctrl: RTL

UD_COUNTER_CTRL -- requirements
Module: ud_counter_ctrl

---
 rtl/udc_pkg.sv | 27 ++
 rtl/ud_counter_ctrl_if.sv | 29 ++
 rtl/ud_counter_ctrl_arb.sv | 24 ++
 rtl/ud_counter_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/udc_pkg.sv
// Shared types and constants for the up/down counter controller.
// Build option UDC_SHORTEST_PATH_EN selects wrap-around shortest-path stepping.
package udc_pkg;

  localparam int unsigned CNT_W        = 4;
  localparam int unsigned PACE_W       = 4;
  localparam int unsigned STEP_DIV_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DONE
  } state_e;

  // Returns 1 when the next step toward tgt should be an increment.
  function automatic logic step_up(input logic [CNT_W-1:0] tgt,
                                   input logic [CNT_W-1:0] cnt);
`ifdef UDC_SHORTEST_PATH_EN
    logic [CNT_W-1:0] d;
    d = tgt - cnt;
    return (d != '0) && (d <= CNT_W'(8));
`else
    return tgt > cnt;
`endif
  endfunction

endpackage

// File: rtl/ud_counter_ctrl_if.sv
// Requester and external-counter signals of the up/down counter controller.
interface ud_counter_ctrl_if;
  import udc_pkg::*;

  logic             req0;
  logic             req1;
  logic [CNT_W-1:0] tgt0;
  logic [CNT_W-1:0] tgt1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic             cnt_en;
  logic             cnt_up;
  logic             cnt_down;

  modport master (
    output req0, req1, tgt0, tgt1, cnt,
    input  gnt0, gnt1, done0, done1, busy, cnt_en, cnt_up, cnt_down
  );

  modport slave (
    input  req0, req1, tgt0, tgt1, cnt,
    output gnt0, gnt1, done0, done1, busy, cnt_en, cnt_up, cnt_down
  );

endinterface

// File: rtl/ud_counter_ctrl_arb.sv
// Two-requester round-robin arbiter with a 1-bit priority pointer.
module rr_arb_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q;

  always_comb begin
    grant = '0;
    if (req == 2'b11) grant[ptr_q] = 1'b1;
    else              grant = req;
  end

  // After a grant the pointer favours the requester that was not served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    ptr_q <= 1'b0;
    else if (advance && |grant) ptr_q <= ~grant[1];
  end

endmodule

// File: rtl/ud_counter_ctrl.sv
// Arbitrates two move requests and paces an external up/down counter to the target.
// Build option UDC_SHORTEST_PATH_EN enables wrap-around shortest-path direction.
module ud_counter_ctrl
  import udc_pkg::*;
#(
  parameter int unsigned STEP_DIV = STEP_DIV_DEF
) (
  input logic              clk,
  input logic              rst,
  ud_counter_ctrl_if.slave bus
);

  localparam logic [PACE_W-1:0] PACE_MAX = PACE_W'(STEP_DIV - 1);

  state_e            state_q;
  logic [PACE_W-1:0] pace_q, pace_d;
  logic [CNT_W-1:0]  tgt_q;
  logic              owner_q;
  logic              gnt0_q, gnt1_q, done0_q, done1_q;
  logic              busy_q, cnt_en_q, up_q, down_q;
  logic [1:0]        grant;
  logic              step_up_d;

  rr_arb_2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({bus.req1, bus.req0}),
    .advance (state_q == IDLE),
    .grant   (grant)
  );

  assign pace_d    = (pace_q == PACE_MAX) ? '0 : pace_q + PACE_W'(1);
  assign step_up_d = step_up(tgt_q, bus.cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pace_q   <= '0;
      tgt_q    <= '0;
      owner_q  <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      cnt_en_q <= 1'b0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
    end else begin
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      cnt_en_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (|grant) begin
            gnt0_q  <= grant[0];
            gnt1_q  <= grant[1];
            tgt_q   <= grant[1] ? bus.tgt1 : bus.tgt0;
            owner_q <= grant[1];
            pace_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= MOVE;
          end
        end
        MOVE: begin
          pace_q <= pace_d;
          if (pace_q == PACE_MAX) begin
            if (bus.cnt == tgt_q) state_q <= DONE;
            else if (step_up_d)   up_q    <= 1'b1;
            else                  down_q  <= 1'b1;
          end
        end
        DONE: begin
          done0_q <= ~owner_q;
          done1_q <= owner_q;
          busy_q  <= 1'b0;
          pace_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.busy     = busy_q;
  assign bus.cnt_en   = cnt_en_q;
  assign bus.cnt_up   = up_q;
  assign bus.cnt_down = down_q;

endmodule
